// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: instruction-memory request/response bus between fetch stage and imem.
interface if_fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    modport master (output req, addr, input ack, rdata);
    modport slave (input req, addr, output ack, rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC, single-outstanding imem fetch FSM, bundle FIFO and IF/ID register.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p1_pipeline_regWrite,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_target,
    if_fetch_stage_if.master      imem,
    output logic [15:0]           p1_aluInstr,
    output logic [15:0]           p1_memInstr,
    output logic [31:0]           p1_pc,
    output logic                  p1_valid
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(BUF_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t        state;
    logic          req;
    logic [31:0]   pc;
    logic [31:0]   tgt;
    logic [31:0]   buf_pc   [BUF_DEPTH];
    logic [31:0]   buf_data [BUF_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   next_count;
    logic [31:0]   target;
    logic          push;
    logic          pop;

    assign target     = redirect_target & ~32'h3;
    assign push       = state == REQ && imem.ack && !redirect_valid;
    assign pop        = p1_pipeline_regWrite && count != '0 && !redirect_valid;
    assign next_count = count + (AW+1)'(push) - (AW+1)'(pop);
    assign imem.req   = req;
    assign imem.addr  = pc;

    // In DRAIN, pc keeps the outstanding address; the redirect target waits in tgt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            req   <= 1'b0;
            pc    <= RESET_PC;
            tgt   <= RESET_PC;
        end else begin
            unique case (state)
                IDLE: if (redirect_valid || count < DEPTH_C) begin
                    state <= REQ;
                    req   <= 1'b1;
                    pc    <= redirect_valid ? target : pc;
                end
                REQ: if (imem.ack) begin
                    pc    <= redirect_valid ? target : pc + 32'd4;
                    state <= (redirect_valid || next_count < DEPTH_C) ? REQ : IDLE;
                    req   <= redirect_valid || next_count < DEPTH_C;
                end else if (redirect_valid) begin
                    state <= DRAIN;
                    tgt   <= target;
                end
                DRAIN: if (imem.ack) begin
                    state <= REQ;
                    pc    <= redirect_valid ? target : tgt;
                end else if (redirect_valid) begin
                    tgt <= target;
                end
                default: begin
                    state <= IDLE;
                    req   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_ptr]   <= pc;
            buf_data[wr_ptr] <= imem.rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            p1_aluInstr <= NOP_INSTR;
            p1_memInstr <= NOP_INSTR;
            p1_pc       <= 32'h0;
            p1_valid    <= 1'b0;
        end else if (redirect_valid) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            p1_aluInstr <= NOP_INSTR;
            p1_memInstr <= NOP_INSTR;
            p1_valid    <= 1'b0;
        end else begin
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= next_count;
            if (p1_pipeline_regWrite) begin
                p1_aluInstr <= pop ? buf_data[rd_ptr][15:0] : NOP_INSTR;
                p1_memInstr <= pop ? buf_data[rd_ptr][31:16] : NOP_INSTR;
                p1_pc       <= pop ? buf_pc[rd_ptr] : p1_pc;
                p1_valid    <= pop;
            end
        end
    end
endmodule
